// File: rtl/car_sensor.sv
// Prospect loop detector: 2-flop sync, debounce, and queued-car request FSM for the stoplight controller.
// Optional stuck-sensor detection (sticky fault, forces car_present) is built when CAR_SENSOR_STUCK_DET_EN is defined.
module car_sensor #(
    parameter int DEBOUNCE    = 4,
    parameter int STUCK_LIMIT = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sensor_raw,
    input  logic [2:0] light_pros,
    output logic       car_present,
    output logic [3:0] car_count,
    output logic       sensor_fault
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] SERVE = 2'd2;
    localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE - 1);

    logic       s1, s2, deb;
    logic [7:0] deb_cnt;
    logic [1:0] state;
    logic       green;
    logic       arrival;

    assign green   = (light_pros == 3'b100);
    // Rising debounce update; coincides with the edge that sets deb.
    assign arrival = s2 && !deb && (deb_cnt == DEB_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            deb     <= 1'b0;
            deb_cnt <= 8'd0;
        end else begin
            s1 <= sensor_raw;
            s2 <= s1;
            if (s2 == deb) begin
                deb_cnt <= 8'd0;
            end else if (deb_cnt == DEB_LAST) begin
                deb     <= s2;
                deb_cnt <= 8'd0;
            end else begin
                deb_cnt <= deb_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            car_count <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (green) begin
                        state <= SERVE;
                    end else if (arrival) begin
                        state     <= WAIT;
                        car_count <= 4'd1;
                    end
                end
                WAIT: begin
                    if (green) begin
                        state     <= SERVE;
                        car_count <= 4'd0;
                    end else if (arrival && car_count != 4'd15) begin
                        car_count <= car_count + 4'd1;
                    end
                end
                SERVE: begin
                    // A car still on the loop when green ends is already waiting.
                    if (!green) begin
                        if (deb) begin
                            state     <= WAIT;
                            car_count <= 4'd1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    car_count <= 4'd0;
                end
            endcase
        end
    end

`ifdef CAR_SENSOR_STUCK_DET_EN
    logic [15:0] stuck_cnt;
    logic [15:0] stuck_next;

    assign stuck_next = !deb ? 16'd0 :
                        (stuck_cnt == 16'hFFFF) ? stuck_cnt : stuck_cnt + 16'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            stuck_cnt    <= 16'd0;
            sensor_fault <= 1'b0;
        end else begin
            stuck_cnt <= stuck_next;
            if (stuck_next == 16'(STUCK_LIMIT)) begin
                sensor_fault <= 1'b1;
            end
        end
    end

    // Fail-safe: a stuck loop keeps requesting green so Prospect still cycles.
    assign car_present = (state == WAIT) || sensor_fault;
`else
    assign sensor_fault = 1'b0;
    assign car_present  = (state == WAIT);
`endif

endmodule

// File: tb/tb_car_sensor.sv
// Bench for car_sensor: directed scenarios plus randomized raw/light traffic checked against a cycle model
// built from run-length debounce and a car-queue abstraction.
module tb_car_sensor;
    localparam int DEB = 4;
    localparam int STK = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sensor_raw = 1'b0;
    logic [2:0] light_pros = 3'b001;
    logic       car_present;
    logic [3:0] car_count;
    logic       sensor_fault;

    int checks = 0;
    int errors = 0;

    car_sensor #(.DEBOUNCE(DEB), .STUCK_LIMIT(STK)) dut (
        .clk         (clk),
        .rst         (rst),
        .sensor_raw  (sensor_raw),
        .light_pros  (light_pros),
        .car_present (car_present),
        .car_count   (car_count),
        .sensor_fault(sensor_fault)
    );

    always #5 clk = ~clk;

    typedef enum int {M_IDLE, M_WAIT, M_SERVE} mode_t;
    mode_t m_mode = M_IDLE;
    bit    m_s1 = 0, m_s2 = 0, m_deb = 0, m_fault = 0;
    int    m_cars = 0;
    int    m_high = 0;
    bit    win[$];

    function automatic logic [5:0] exp_vec();
        int c;
        c = (m_cars > 15) ? 15 : m_cars;
        return {((m_mode == M_WAIT) || m_fault), 4'(c), m_fault};
    endfunction

    // Advance one clock edge and update the model from the inputs that edge sampled.
    task automatic step();
        bit arr, old_deb, g, all_diff;
        @(posedge clk);
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_deb = 0; m_fault = 0;
            m_mode = M_IDLE; m_cars = 0; m_high = 0;
            win.delete();
        end else begin
            arr = 0;
            old_deb = m_deb;
            g = (light_pros == 3'b100);
            win.push_back(m_s2);
            if (win.size() > DEB) void'(win.pop_front());
            all_diff = (win.size() == DEB);
            foreach (win[i]) if (win[i] == m_deb) all_diff = 0;
            if (all_diff) begin
                m_deb = m_s2;
                arr = m_deb;
                win.delete();
            end
            case (m_mode)
                M_IDLE:  if (g) m_mode = M_SERVE;
                         else if (arr) begin m_mode = M_WAIT; m_cars = 1; end
                M_WAIT:  if (g) begin m_mode = M_SERVE; m_cars = 0; end
                         else if (arr) m_cars++;
                default: if (!g) begin
                             if (old_deb) begin m_mode = M_WAIT; m_cars = 1; end
                             else m_mode = M_IDLE;
                         end
            endcase
            m_high = old_deb ? m_high + 1 : 0;
`ifdef CAR_SENSOR_STUCK_DET_EN
            if (m_high >= STK) m_fault = 1;
`endif
            m_s2 = m_s1;
            m_s1 = sensor_raw;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        sensor_raw = 1'b1;
        light_pros = 3'b001;
        rst = 1'b1;
        repeat (3) step();
        checks++;
        if ({car_present, car_count, sensor_fault} !== 6'd0) begin
            errors++;
            $display("FAIL reset: got present=%0b count=%0d fault=%0b, want all 0",
                     car_present, car_count, sensor_fault);
        end
        rst = 1'b0;
        sensor_raw = 1'b0;
    endtask

    task automatic test_latency();
        do_reset();
        light_pros = 3'b001;
        sensor_raw = 1'b0;
        repeat (3) step();
        sensor_raw = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (car_present !== (i >= DEB + 1)) begin
                errors++;
                $display("FAIL latency edge+%0d: present=%0b want %0b", i, car_present, (i >= DEB + 1));
            end
            checks++;
            if ({car_present, car_count, sensor_fault} !== exp_vec()) begin
                errors++;
                $display("FAIL latency_model edge+%0d: got %b want %b", i,
                         {car_present, car_count, sensor_fault}, exp_vec());
            end
        end
        checks++;
        if (car_count !== 4'd1) begin
            errors++;
            $display("FAIL latency_count: got %0d want 1", car_count);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        light_pros = 3'b001;
        sensor_raw = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (i == DEB - 1) sensor_raw = 1'b0;
            step();
            checks++;
            if (car_present !== 1'b0 || car_count !== 4'd0) begin
                errors++;
                $display("FAIL glitch cycle %0d: present=%0b count=%0d want 0/0", i, car_present, car_count);
            end
        end
    endtask

    task automatic test_saturate();
        do_reset();
        light_pros = 3'b001;
        for (int a = 1; a <= 17; a++) begin
            sensor_raw = 1'b1;
            repeat (6) step();
            sensor_raw = 1'b0;
            repeat (10) step();
            checks++;
            if (car_count !== 4'((a > 15) ? 15 : a) || car_count !== exp_vec()[4:1]) begin
                errors++;
                $display("FAIL saturate arrival %0d: count=%0d want %0d", a, car_count, (a > 15) ? 15 : a);
            end
        end
        light_pros = 3'b100;
        step();
        checks++;
        if (car_count !== 4'd0 || car_present !== 1'b0) begin
            errors++;
            $display("FAIL saturate_green: count=%0d present=%0b want 0/0", car_count, car_present);
        end
    endtask

    task automatic test_green_arrival();
        do_reset();
        light_pros = 3'b001;
        sensor_raw = 1'b1;
        repeat (6) step();
        sensor_raw = 1'b0;
        repeat (10) step();
        checks++;
        if (car_present !== 1'b1 || car_count !== 4'd1) begin
            errors++;
            $display("FAIL green_arrival_setup: present=%0b count=%0d want 1/1", car_present, car_count);
        end
        sensor_raw = 1'b1;
        repeat (DEB + 1) step();
        light_pros = 3'b100;
        step();
        checks++;
        if (car_count !== 4'd0 || car_present !== 1'b0) begin
            errors++;
            $display("FAIL green_arrival_same_edge: count=%0d present=%0b want 0/0", car_count, car_present);
        end
        light_pros = 3'b001;
        step();
        checks++;
        if (car_count !== 4'd1 || car_present !== 1'b1) begin
            errors++;
            $display("FAIL green_end_sensor_high: count=%0d present=%0b want 1/1", car_count, car_present);
        end
        sensor_raw = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        light_pros = 3'b001;
        for (int a = 0; a < 3; a++) begin
            sensor_raw = 1'b1;
            repeat (6) step();
            sensor_raw = 1'b0;
            repeat (10) step();
        end
        checks++;
        if (car_count !== 4'd3) begin
            errors++;
            $display("FAIL midwait_setup: count=%0d want 3", car_count);
        end
        sensor_raw = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({car_present, car_count, sensor_fault} !== 6'd0) begin
            errors++;
            $display("FAIL midwait_reset: present=%0b count=%0d fault=%0b want 0", car_present, car_count, sensor_fault);
        end
        for (int j = 0; j < 8; j++) begin
            step();
            checks++;
            if ({car_present, car_count, sensor_fault} !== exp_vec() || (j < DEB + 1 && car_present !== 1'b0)) begin
                errors++;
                $display("FAIL midwait_redebounce edge+%0d: got %b want %b", j,
                         {car_present, car_count, sensor_fault}, exp_vec());
            end
        end
        sensor_raw = 1'b0;
    endtask

    task automatic test_stuck();
        logic exp_fault;
`ifdef CAR_SENSOR_STUCK_DET_EN
        exp_fault = 1'b1;
`else
        exp_fault = 1'b0;
`endif
        do_reset();
        sensor_raw = 1'b1;
        for (int i = 0; i < 30; i++) begin
            light_pros = ((i / 3) % 3 == 0) ? 3'b001 : ((i / 3) % 3 == 1) ? 3'b010 : 3'b100;
            step();
            checks++;
            if ({car_present, car_count, sensor_fault} !== exp_vec()) begin
                errors++;
                $display("FAIL stuck_model cycle %0d: got %b want %b", i,
                         {car_present, car_count, sensor_fault}, exp_vec());
            end
        end
        checks++;
        if (sensor_fault !== exp_fault || (exp_fault && car_present !== 1'b1)) begin
            errors++;
            $display("FAIL stuck_flag: fault=%0b present=%0b want fault=%0b", sensor_fault, car_present, exp_fault);
        end
        sensor_raw = 1'b0;
        light_pros = 3'b001;
        repeat (12) step();
        checks++;
        if (sensor_fault !== exp_fault) begin
            errors++;
            $display("FAIL stuck_sticky: fault=%0b want %0b", sensor_fault, exp_fault);
        end
        do_reset();
        step();
        checks++;
        if (sensor_fault !== 1'b0) begin
            errors++;
            $display("FAIL stuck_cleared: fault=%0b want 0", sensor_fault);
        end
    endtask

    task automatic test_random();
        int raw_hold, light_hold;
        do_reset();
        raw_hold = 0;
        light_hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (raw_hold == 0) begin
                sensor_raw = ~sensor_raw;
                raw_hold = $urandom_range(1, 12);
            end
            raw_hold--;
            if (light_hold == 0) begin
                case ($urandom_range(0, 4))
                    0, 1:    light_pros = 3'b001;
                    2:       light_pros = 3'b100;
                    3:       light_pros = 3'b010;
                    default: light_pros = 3'($urandom_range(0, 7));
                endcase
                light_hold = $urandom_range(1, 40);
            end
            light_hold--;
            rst = ($urandom_range(0, 199) == 0);
            step();
            checks++;
            if ({car_present, car_count, sensor_fault} !== exp_vec()) begin
                errors++;
                $display("FAIL random cycle %0d: got present/count/fault=%b want %b", i,
                         {car_present, car_count, sensor_fault}, exp_vec());
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_saturate();
        test_green_arrival();
        test_reset_mid_wait();
        test_stuck();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/car_sensor.md
CAR_SENSOR -- requirements
Module: car_sensor

Interface
REQ-001 Parameter DEBOUNCE, default 4: cycles the synchronized sensor must hold a new level before it is accepted; legal range 2..255.
REQ-002 Parameter STUCK_LIMIT, default 1024: cycles of continuous debounced-high before the sensor is declared stuck; legal range 2..65535.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 sensor_raw  input  1  asynchronous Prospect loop-detector level; 1 = metal over the loop.
REQ-006 light_pros  input  3  Prospect light from the stoplight controller, one-hot: bit0 red, bit1 yellow, bit2 green.
REQ-007 car_present  output  1  waiting-car request to the stoplight controller.
REQ-008 car_count  output  4  cars queued since the last Prospect green; saturates at 15.
REQ-009 sensor_fault  output  1  sticky stuck-sensor flag.

Function
REQ-010 sensor_raw SHALL pass through a 2-flop synchronizer (s1, s2) before any other use.
REQ-011 Debounce: counter clears when s2 equals debounced level deb; else increments; when counter is DEBOUNCE-1 and s2 still differs, deb takes s2 and counter clears on that edge.
REQ-012 Latency: raw held high, first sampled at edge N, SHALL make deb rise at edge N+DEBOUNCE+1; any s2 pulse shorter than DEBOUNCE cycles SHALL leave deb unchanged.
REQ-013 Arrival: deb 0->1 update, taken on the same edge that updates deb.
REQ-014 FSM states: IDLE, WAIT, SERVE.
REQ-015 IDLE->WAIT on arrival while light_pros[2]=0; car_count becomes 1.
REQ-016 IDLE->SERVE when light_pros[2]=1; arrivals in SERVE are not counted because the car proceeds on green.
REQ-017 WAIT: each further arrival increments car_count, saturating at 15.
REQ-018 WAIT->SERVE when light_pros[2]=1; car_count clears to 0 on that edge, even if an arrival occurs on the same edge.
REQ-019 SERVE->IDLE when light_pros[2]=0 and deb=0.
REQ-020 SERVE->WAIT when light_pros[2]=0 and deb=1, since a car is still on the loop; car_count becomes 1.
REQ-021 car_present SHALL equal (state==WAIT), registered state only, with no combinational path from light_pros.
REQ-022 light_pros values other than 3'b100 SHALL be treated as not green; no other decoding.

Reset
REQ-023 On rst, the following take effect on the next edge regardless of state:
  - s1, s2, deb = 0
  - debounce counter = 0
  - state = IDLE
  - car_count = 0
  - car_present = 0
  - stuck counter = 0
  - sensor_fault = 0
REQ-024 rst asserted mid-debounce or mid-WAIT SHALL discard pending arrivals; a sensor still high after rst SHALL re-debounce from zero.

Configuration
REQ-025 Macro CAR_SENSOR_STUCK_DET_EN SHALL enable stuck detection.
REQ-026 Defined: a 16-bit counter increments while deb=1 (saturating) and clears when deb=0.
REQ-027 Defined: when the stuck counter reaches STUCK_LIMIT, sensor_fault sets and holds until rst.
REQ-028 Defined: while sensor_fault=1, car_present SHALL be forced 1 (fail-safe cycling).
REQ-029 Undefined: no stuck counter is built, sensor_fault is tied 0, and car_present follows REQ-021 only.

Verification
REQ-030 DEBOUNCE=4, light red, raw 0->1 sampled at edge 10 and held -> deb and car_present rise after edge 15; car_count=1.
REQ-031 Raw high for 3 cycles then low, light red -> car_present stays 0 and car_count stays 0 throughout.
REQ-032 Light red, 17 debounced arrivals separated by gaps of at least 2*DEBOUNCE cycles -> car_count saturates at 15; light_pros=100 -> next edge car_count=0, car_present=0.
REQ-033 In WAIT, arrival and light_pros=100 on the same edge -> state SERVE, car_count=0; light back to 001 with sensor high -> WAIT, car_count=1, car_present=1.
REQ-034 With CAR_SENSOR_STUCK_DET_EN, STUCK_LIMIT=8, raw held high while light cycles -> sensor_fault=1 after 8 debounced-high cycles, car_present=1 until rst; without the macro -> sensor_fault stays 0.
REQ-035 rst pulsed for 1 cycle while in WAIT with car_count=3 -> next edge all outputs 0, state IDLE.
